in_port: RTL and testbench

IN_PORT -- requirements
Module: in_port

---
 rtl/in_port.sv | 114 +++++++++++
 tb/tb_in_port.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/in_port.sv
// Four-port synchronised input block with change flags, read decode and optional masked IRQ.
// Define INPORT_IRQ_EN to include the Mask register and IRQ generation.
module in_port (
   input  logic       clk,
   input  logic       Reset,
   input  logic [7:0] Address,
   input  logic       INportRead,
   input  logic       INportWrite,
   input  logic [7:0] Datain,
   input  logic [7:0] InExtWorld1,
   input  logic [7:0] InExtWorld2,
   input  logic [7:0] InExtWorld3,
   input  logic [7:0] InExtWorld4,
   output logic [7:0] Dataout,
   output logic       IRQ
);
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 8;
   localparam int unsigned NP = 4;

   localparam logic [AW-1:0] ADDR_STATUS = AW'(8'h04);
   localparam logic [AW-1:0] ADDR_MASK   = AW'(8'h05);

   logic [DW-1:0] ext      [NP];
   logic [DW-1:0] sync1    [NP];
   logic [DW-1:0] sync2    [NP];
   logic [DW-1:0] data_reg [NP];
   logic [NP-1:0] flag;
   logic [NP-1:0] flag_nxt;
   logic [NP-1:0] mask;
   logic [DW-1:0] rd_data_c;

   assign ext[0] = InExtWorld1;
   assign ext[1] = InExtWorld2;
   assign ext[2] = InExtWorld3;
   assign ext[3] = InExtWorld4;

   // A data read clears its flag, but a change seen on the same edge wins.
   always_comb begin
      flag_nxt = flag;
      for (int n = 0; n < int'(NP); n++) begin
         if (INportRead && (Address == AW'(n)))
            flag_nxt[n] = 1'b0;
         if (sync2[n] != data_reg[n])
            flag_nxt[n] = 1'b1;
      end
   end

   // Read decode uses pre-edge state, so a coincident mask write is not visible.
   always_comb begin
      rd_data_c = '0;
      case (Address)
         AW'(8'h00):  rd_data_c = data_reg[0];
         AW'(8'h01):  rd_data_c = data_reg[1];
         AW'(8'h02):  rd_data_c = data_reg[2];
         AW'(8'h03):  rd_data_c = data_reg[3];
         ADDR_STATUS: rd_data_c = {(DW-NP)'(0), flag};
         ADDR_MASK:   rd_data_c = {(DW-NP)'(0), mask};
         default:     rd_data_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int n = 0; n < int'(NP); n++) begin
            sync1[n]    <= '0;
            sync2[n]    <= '0;
            data_reg[n] <= '0;
         end
         flag    <= '0;
         Dataout <= '0;
      end else begin
         for (int n = 0; n < int'(NP); n++) begin
            sync1[n]    <= ext[n];
            sync2[n]    <= sync1[n];
            data_reg[n] <= sync2[n];
         end
         flag <= flag_nxt;
         if (INportRead)
            Dataout <= rd_data_c;
      end
   end

`ifdef INPORT_IRQ_EN
   logic [NP-1:0] mask_nxt;
   logic          unused_datain;

   always_comb begin
      mask_nxt = mask;
      if (INportWrite && (Address == ADDR_MASK))
         mask_nxt = Datain[NP-1:0];
   end

   // IRQ follows next-state flags so a clearing read drops it on the same edge.
   always_ff @(posedge clk) begin
      if (Reset) begin
         mask <= '0;
         IRQ  <= 1'b0;
      end else begin
         mask <= mask_nxt;
         IRQ  <= |(flag_nxt & mask_nxt);
      end
   end

   assign unused_datain = ^Datain[DW-1:NP];
`else
   logic unused_write;

   assign mask         = '0;
   assign IRQ          = 1'b0;
   assign unused_write = ^{Datain, INportWrite};
`endif

endmodule

// File: tb/tb_in_port.sv
// Directed self-checking bench for in_port; expectations follow INPORT_IRQ_EN when defined.
module tb_in_port;
`ifdef INPORT_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif
   localparam logic [7:0] MASK_EXP = IRQ_EN ? 8'h0F : 8'h00;

   logic       clk = 1'b0;
   logic       Reset;
   logic [7:0] Address;
   logic       INportRead;
   logic       INportWrite;
   logic [7:0] Datain;
   logic [7:0] InExtWorld1, InExtWorld2, InExtWorld3, InExtWorld4;
   logic [7:0] Dataout;
   logic       IRQ;

   int n_checks = 0;
   int n_errors = 0;

   in_port dut (
      .clk         (clk),
      .Reset       (Reset),
      .Address     (Address),
      .INportRead  (INportRead),
      .INportWrite (INportWrite),
      .Datain      (Datain),
      .InExtWorld1 (InExtWorld1),
      .InExtWorld2 (InExtWorld2),
      .InExtWorld3 (InExtWorld3),
      .InExtWorld4 (InExtWorld4),
      .Dataout     (Dataout),
      .IRQ         (IRQ)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [7:0] addr);
      Address    = addr;
      INportRead = 1'b1;
      tick();
      INportRead = 1'b0;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      Address     = addr;
      Datain      = data;
      INportWrite = 1'b1;
      tick();
      INportWrite = 1'b0;
   endtask

   initial begin
      Reset       = 1'b1;
      Address     = 8'h00;
      INportRead  = 1'b0;
      INportWrite = 1'b0;
      Datain      = 8'h00;
      InExtWorld1 = 8'h00;
      InExtWorld2 = 8'h00;
      InExtWorld3 = 8'h00;
      InExtWorld4 = 8'h00;
      tick();
      tick();
      check("reset_dataout", Dataout, 8'h00);
      check("reset_irq", 8'(IRQ), 8'h00);
      Reset = 1'b0;

      // Zero inputs after reset release must not raise flags
      repeat (4) tick();
      rd(8'h04);
      check("idle_status", Dataout, 8'h00);

      // Port 2: 0xA5 visible after the 3rd edge
      InExtWorld2 = 8'hA5;
      tick();
      tick();
      tick();
      rd(8'h04);
      check("p2_status_set", Dataout, 8'h02);
      rd(8'h01);
      check("p2_data", Dataout, 8'hA5);
      rd(8'h04);
      check("p2_status_clr", Dataout, 8'h00);

      // Port 3: read on the 3rd edge returns the old value and set beats clear
      InExtWorld3 = 8'h11;
      tick();
      tick();
      rd(8'h02);
      check("p3_latency_old", Dataout, 8'h00);
      rd(8'h04);
      check("p3_set_wins", Dataout, 8'h04);
      rd(8'h02);
      check("p3_data", Dataout, 8'h11);
      rd(8'h04);
      check("p3_status_clr", Dataout, 8'h00);

      // Port 1: same coincidence on address 0x00
      InExtWorld1 = 8'h5A;
      tick();
      tick();
      rd(8'h00);
      check("p1_coincide_old", Dataout, 8'h00);
      rd(8'h04);
      check("p1_set_wins", Dataout, 8'h01);
      rd(8'h04);
      check("status_no_clear", Dataout, 8'h01);
      rd(8'h00);
      check("p1_data", Dataout, 8'h5A);
      rd(8'h04);
      check("p1_status_clr", Dataout, 8'h00);

      // Mask write and IRQ timing on port 4
      wr(8'h05, 8'h0F);
      rd(8'h05);
      check("mask_read", Dataout, MASK_EXP);
      check("irq_idle", 8'(IRQ), 8'h00);
      InExtWorld4 = 8'h3C;
      tick();
      tick();
      check("irq_before_flag", 8'(IRQ), 8'h00);
      tick();
      check("irq_with_flag", 8'(IRQ), 8'(IRQ_EN));
      tick();
      check("irq_hold", 8'(IRQ), 8'(IRQ_EN));
      rd(8'h03);
      check("p4_data", Dataout, 8'h3C);
      check("irq_clr_same_edge", 8'(IRQ), 8'h00);

      // Simultaneous read and write of the mask returns the pre-write value
      Address     = 8'h05;
      Datain      = 8'h03;
      INportRead  = 1'b1;
      INportWrite = 1'b1;
      tick();
      INportRead  = 1'b0;
      INportWrite = 1'b0;
      check("rw_pre_mask", Dataout, MASK_EXP);
      rd(8'h05);
      check("rw_post_mask", Dataout, IRQ_EN ? 8'h03 : 8'h00);
      wr(8'h05, 8'h0F);

      // Unmapped reads, Dataout hold, ignored writes
      rd(8'h00);
      tick();
      tick();
      check("dataout_hold", Dataout, 8'h5A);
      rd(8'h06);
      check("rd_06", Dataout, 8'h00);
      rd(8'h01);
      rd(8'hFF);
      check("rd_ff", Dataout, 8'h00);
      wr(8'h02, 8'hFF);
      rd(8'h02);
      check("wr02_data", Dataout, 8'h11);
      rd(8'h05);
      check("wr02_mask", Dataout, MASK_EXP);
      rd(8'h04);
      check("wr02_status", Dataout, 8'h00);

      // All flags set with mask 0x0F, then reset with a read in flight
      InExtWorld1 = 8'h01;
      InExtWorld2 = 8'h02;
      InExtWorld3 = 8'h03;
      InExtWorld4 = 8'h04;
      tick();
      tick();
      tick();
      rd(8'h04);
      check("all_flags", Dataout, 8'h0F);
      check("all_flags_irq", 8'(IRQ), 8'(IRQ_EN));
      Address    = 8'h04;
      INportRead = 1'b1;
      Reset      = 1'b1;
      tick();
      Reset      = 1'b0;
      INportRead = 1'b0;
      check("rst_dataout", Dataout, 8'h00);
      check("rst_irq", 8'(IRQ), 8'h00);
      rd(8'h04);
      check("rst_status", Dataout, 8'h00);
      rd(8'h05);
      check("rst_mask", Dataout, 8'h00);

      // Nonzero inputs re-flag once they propagate after release
      tick();
      rd(8'h04);
      check("post_rst_flags", Dataout, 8'h0F);
      rd(8'h03);
      check("post_rst_data4", Dataout, 8'h04);
      check("post_rst_irq", 8'(IRQ), 8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
